sum_fnd_ctrl: RTL and testbench
===============================

// Module: sum_fnd_ctrl
// PURPOSE
//  Downstream display stage of the Sum dedicated CPU: captures the binary sum from the output buffer on a load strobe.
//  Converts it to 4-digit BCD with a sequential double-dabble, and drives the Basys3 4-digit common-anode FND by time-multiplexed scanning.
//  Sits between the Sum datapath output buffer and the board 7-segment pins.
// PARAMETERS
//  DATA_W   14           width of iData (max 16383)
//  CLK_HZ   100_000_000  iClk frequency
//  SCAN_HZ  1000         per-digit scan rate; DIV = CLK_HZ/SCAN_HZ clocks per digit (DIV >= 2)
// PORTS
//  iClk      in   1       clock, rising edge
//  iRst      in   1       reset, asynchronous, active-high
//  iData     in   DATA_W  unsigned binary value from output buffer
//  iLoad     in   1       one-cycle strobe: capture iData and start conversion
//  oBusy     out  1       high while a conversion is in progress (CONV, DONE)
//  oFndCom   out  4       digit enables, active-low; bit0 = ones digit
//  oFndFont  out  8       segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1
// BEHAVIOUR
//  Reset: state IDLE, oBusy=0, display BCD=0000, prescaler=0, digit idx=0, oFndCom=4'hF, oFndFont=8'hFF.
//   Reset acts at any time, including mid-conversion; the partial result is discarded.
//  Conversion FSM (IDLE/CONV/DONE):
//   IDLE: when iLoad=1, capture iData into a shift register, clear the BCD accumulator, set bit count to DATA_W, and go to CONV.
//   CONV: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1 and decrement the count.
//    After DATA_W cycles, go to DONE.
//   DONE: if the captured value > 9999, load display with overflow (all four digits = dash 8'hBF).
//    Otherwise load the display register with the 4 BCD nibbles. Return to IDLE.
//   Latency: iLoad sampled at edge 0 -> display register updated at edge DATA_W+2.
//   iLoad while oBusy=1: ignored, not queued. iLoad in the same cycle DONE is exiting: ignored.
//  Scan:
//   The prescaler counts 0..DIV-1 and wraps. At DIV-1, the digit index increments mod 4 (3 -> 0).
//   Outputs are registered: each cycle oFndCom = ~(1<<idx) and oFndFont = font(display nibble idx).
//    So outputs lag idx by 1 clock. The first post-reset edge shows digit 0.
//  Display update is atomic: all 4 nibbles and the overflow flag change on the same edge. Scanning is never paused.
//  Fonts (gfedcba, active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 dash=BF blank=FF.
// CONFIGURATION
//  FND_BLANK_EN defined:
//   Leading-zero blanking. Digits 3..1 that are 0 and have only zeros above them output 8'hFF; COM is still driven.
//   The ones digit is always shown. Overflow dashes are never blanked.
//  FND_BLANK_EN undefined: all four digits always shown, e.g. 55 -> "0055".
// STRUCTURE
//  Package sum_fnd_pkg: conv_state_e enum {IDLE,CONV,DONE}; FONT_0..FONT_9, FONT_DASH, FONT_BLANK localparams; function font_of(logic [3:0]).
//  Sub-module bin2bcd_seq (parameter DATA_W):
//   Ports: iClk, iRst, iStart, iBin, oBusy, oDone (1-cycle), oBcd[15:0], oOvf. Holds the FSM.
//   sum_fnd_ctrl holds the display register, prescaler, digit index and font mux.
// TESTING (bench overrides CLK_HZ=8, SCAN_HZ=2 -> DIV=4)
//  Reset then release -> oFndCom cycles 1110,1101,1011,0111 every 4 clks; fonts C0 each (no blank) or FF,FF,FF,C0 (FND_BLANK_EN).
//  iLoad with iData=55 -> oBusy high exactly 15 clks (14 CONV+1 DONE); then digits 3..0 = C0,C0,92,92 (blank: FF,FF,92,92).
//  iData=9999 -> 90,90,90,90; iData=10000 and 16383 -> BF on all four digits in both builds.
//  iLoad=1 with 1234 held while busy converting 55, then pulsed again mid-CONV -> display stays 0055; next iLoad after idle takes effect.
//  Assert iRst at CONV cycle 7 of a 4321 load -> oBusy=0, display 0000, oFndCom=F/font=FF during reset; no stale 4321 ever shown.
//  iData=0 with FND_BLANK_EN -> FF,FF,FF,C0; iData=100 -> FF,F9,C0,C0 (inner zeros kept).

Source files
------------

// File: rtl/sum_fnd_pkg.sv
// Shared types, 7-segment font constants and BCD helpers for the Sum CPU display stage.
package sum_fnd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  // Segment order {dp,g,f,e,d,c,b,a}, active-low; dp is always off.
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_DASH  = 8'hBF;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  function automatic logic [7:0] font_of(logic [3:0] nib);
    case (nib)
      4'd0:    font_of = FONT_0;
      4'd1:    font_of = FONT_1;
      4'd2:    font_of = FONT_2;
      4'd3:    font_of = FONT_3;
      4'd4:    font_of = FONT_4;
      4'd5:    font_of = FONT_5;
      4'd6:    font_of = FONT_6;
      4'd7:    font_of = FONT_7;
      4'd8:    font_of = FONT_8;
      4'd9:    font_of = FONT_9;
      default: font_of = FONT_BLANK;
    endcase
  endfunction

  // Double-dabble pre-shift correction: every nibble >= 5 gets +3.
  function automatic logic [15:0] dabble_adj(logic [15:0] bcd);
    logic [15:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    return res;
  endfunction

endpackage

// File: rtl/sum_fnd_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, DATA_W shifts per value,
// then a one-cycle DONE that publishes the BCD digits and the >9999 overflow flag.
module bin2bcd_seq
  import sum_fnd_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [DATA_W-1:0] iBin,
  output logic              oBusy,
  output logic              oDone,
  output logic [15:0]       oBcd,
  output logic              oOvf
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  conv_state_e       state;
  logic [DATA_W-1:0] binCap;
  logic [DATA_W-1:0] shReg;
  logic [15:0]       bcdAcc;
  logic [15:0]       bcdAdj;
  logic [CNT_W-1:0]  bitCnt;

  assign bcdAdj = dabble_adj(bcdAcc);
  assign oBusy  = (state != IDLE);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= IDLE;
      binCap <= '0;
      shReg  <= '0;
      bcdAcc <= '0;
      bitCnt <= '0;
      oDone  <= 1'b0;
      oBcd   <= '0;
      oOvf   <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            binCap <= iBin;
            shReg  <= iBin;
            bcdAcc <= '0;
            bitCnt <= CNT_W'(DATA_W);
            state  <= CONV;
          end
        end
        CONV: begin
          {bcdAcc, shReg} <= {bcdAdj, shReg} << 1;
          bitCnt          <= bitCnt - CNT_W'(1);
          if (bitCnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          // A start strobe landing here is dropped on purpose.
          oBcd  <= bcdAcc;
          oOvf  <= (32'(binCap) > 32'd9999);
          oDone <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sum_fnd_ctrl.sv
// Display stage of the Sum CPU: captures a binary sum, converts it to BCD and scans a
// 4-digit common-anode FND. Define FND_BLANK_EN to enable leading-zero blanking.
module sum_fnd_ctrl
  import sum_fnd_pkg::*;
#(
  parameter int DATA_W  = 14,
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [DATA_W-1:0] iData,
  input  logic              iLoad,
  output logic              oBusy,
  output logic [3:0]        oFndCom,
  output logic [7:0]        oFndFont
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             convDone;
  logic             convOvf;
  logic [15:0]      convBcd;
  logic [15:0]      dispBcd;
  logic             dispOvf;
  logic [PRE_W-1:0] preCnt;
  logic [1:0]       digIdx;
  logic [3:0]       curNib;
  logic [7:0]       nextFont;

  bin2bcd_seq #(
    .DATA_W(DATA_W)
  ) uConv (
    .iClk  (iClk),
    .iRst  (iRst),
    .iStart(iLoad),
    .iBin  (iData),
    .oBusy (oBusy),
    .oDone (convDone),
    .oBcd  (convBcd),
    .oOvf  (convOvf)
  );

  // Digits and overflow flag share one load so the panel never shows a mixed value.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      dispBcd <= '0;
      dispOvf <= 1'b0;
    end else if (convDone) begin
      dispBcd <= convBcd;
      dispOvf <= convOvf;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      preCnt <= '0;
      digIdx <= '0;
    end else if (preCnt == PRE_W'(DIV - 1)) begin
      preCnt <= '0;
      digIdx <= digIdx + 2'd1;
    end else begin
      preCnt <= preCnt + PRE_W'(1);
    end
  end

`ifdef FND_BLANK_EN
  logic [3:0] leadZero;
  assign leadZero[3] = (dispBcd[15:12] == 4'd0);
  assign leadZero[2] = leadZero[3] && (dispBcd[11:8] == 4'd0);
  assign leadZero[1] = leadZero[2] && (dispBcd[7:4] == 4'd0);
  assign leadZero[0] = 1'b0;
`endif

  // NOTE: defaults come first in always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    curNib   = dispBcd[{digIdx, 2'b00} +: 4];
    nextFont = font_of(curNib);
    if (dispOvf) nextFont = FONT_DASH;
`ifdef FND_BLANK_EN
    else if (leadZero[digIdx]) nextFont = FONT_BLANK;
`endif
  end

  // Registered pin drivers: they trail digIdx by one clock.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oFndCom  <= 4'hF;
      oFndFont <= FONT_BLANK;
    end else begin
      oFndCom  <= ~(4'b0001 << digIdx);
      oFndFont <= nextFont;
    end
  end

endmodule

// File: tb/tb_sum_fnd_ctrl.sv
// Self-checking bench for sum_fnd_ctrl: fixed vectors, corner sequences and random loads
// against a cycle-counting arithmetic model. Honours FND_BLANK_EN like the design.
`timescale 1ns/1ps
module tb_sum_fnd_ctrl;

  localparam int DATA_W   = 14;
  localparam int DIV      = 4;
  localparam int LAT      = DATA_W + 2;
  localparam int BUSY_LEN = DATA_W + 1;

  logic              iClk  = 1'b0;
  logic              iRst  = 1'b1;
  logic              iLoad = 1'b0;
  logic [DATA_W-1:0] iData = '0;
  logic              oBusy;
  logic [3:0]        oFndCom;
  logic [7:0]        oFndFont;

  int checks   = 0;
  int failures = 0;

  sum_fnd_ctrl #(
    .DATA_W (DATA_W),
    .CLK_HZ (8),
    .SCAN_HZ(2)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iData   (iData),
    .iLoad   (iLoad),
    .oBusy   (oBusy),
    .oFndCom (oFndCom),
    .oFndFont(oFndFont)
  );

  always #5 iClk = ~iClk;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [7:0] fontTab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference model state: scan position, shown value, pending load and busy window.
  int mPre, mIdx, mDisp, mPendVal, mPendLeft, mBusyLeft;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mfont(input int v, input int k);
    int p;
    p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
    if (v > 9999) return 8'hBF;
`ifdef FND_BLANK_EN
    if (k > 0 && v < p) return 8'hFF;
`endif
    return fontTab[(v / p) % 10];
  endfunction

  task automatic model_reset();
    mPre = 0; mIdx = 0; mDisp = 0; mPendVal = 0; mPendLeft = 0; mBusyLeft = 0;
  endtask

  // One clock: predict, advance, then compare all outputs 1 ns after the edge.
  task automatic step();
    logic [3:0] eCom;
    logic [7:0] eFont;
    bit acc;
    int dIn;
    if (iRst) begin
      @(posedge iClk);
      #1;
      model_reset();
      check("rst_com", 32'(oFndCom), 32'hF);
      check("rst_font", 32'(oFndFont), 32'hFF);
      check("rst_busy", 32'(oBusy), 32'h0);
      return;
    end
    eCom  = ~(4'b0001 << mIdx);
    eFont = mfont(mDisp, mIdx);
    acc   = iLoad && (mBusyLeft == 0);
    dIn   = int'(iData);
    @(posedge iClk);
    if (mPre == DIV - 1) begin mPre = 0; mIdx = (mIdx + 1) % 4; end
    else mPre++;
    if (mBusyLeft > 0) mBusyLeft--;
    if (mPendLeft > 0) begin
      mPendLeft--;
      if (mPendLeft == 0) mDisp = mPendVal;
    end
    if (acc) begin mPendVal = dIn; mPendLeft = LAT; mBusyLeft = BUSY_LEN; end
    #1;
    check("scan_com", 32'(oFndCom), 32'(eCom));
    check("scan_font", 32'(oFndFont), 32'(eFont));
    check("busy", 32'(oBusy), 32'(mBusyLeft > 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int v);
    iData = DATA_W'(v);
    iLoad = 1'b1;
    step();
    iLoad = 1'b0;
  endtask

  // Watch one full scan and compare each digit against hand-written fonts {d3,d2,d1,d0}.
  task automatic capture(input string name, input logic [31:0] exp);
    logic [7:0] seen [4];
    for (int k = 0; k < 4; k++) seen[k] = 8'h00;
    for (int i = 0; i < 4 * DIV; i++) begin
      step();
      case (oFndCom)
        4'b1110: seen[0] = oFndFont;
        4'b1101: seen[1] = oFndFont;
        4'b1011: seen[2] = oFndFont;
        4'b0111: seen[3] = oFndFont;
        default: ;
      endcase
    end
    for (int k = 3; k >= 0; k--)
      check($sformatf("%s_d%0d", name, k), 32'(seen[k]), 32'(exp[k*8 +: 8]));
  endtask

  typedef struct {
    int          data;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t vecs [8];
    logic [31:0] zeroFonts;
    int busyCnt;

`ifdef FND_BLANK_EN
    zeroFonts = 32'hFFFFFFC0;
    vecs[0] = '{55,    32'hFFFF9292};
    vecs[4] = '{0,     32'hFFFFFFC0};
    vecs[5] = '{100,   32'hFFF9C0C0};
    vecs[7] = '{5,     32'hFFFFFF92};
`else
    zeroFonts = 32'hC0C0C0C0;
    vecs[0] = '{55,    32'hC0C09292};
    vecs[4] = '{0,     32'hC0C0C0C0};
    vecs[5] = '{100,   32'hC0F9C0C0};
    vecs[7] = '{5,     32'hC0C0C092};
`endif
    vecs[1] = '{9999,  32'h90909090};
    vecs[2] = '{10000, 32'hBFBFBFBF};
    vecs[3] = '{16383, 32'hBFBFBFBF};
    vecs[6] = '{1234,  32'hF9A4B099};

    model_reset();
    #23;
    check("por_com", 32'(oFndCom), 32'hF);
    check("por_font", 32'(oFndFont), 32'hFF);
    check("por_busy", 32'(oBusy), 32'h0);
    iRst = 1'b0;

    capture("idle", zeroFonts);

    for (int v = 0; v < 8; v++) begin
      load(vecs[v].data);
      run(LAT + 1);
      capture($sformatf("vec%0d", vecs[v].data), vecs[v].exp);
    end

    // Busy window length for a single load.
    busyCnt = 0;
    load(55);
    if (oBusy) busyCnt++;
    for (int i = 0; i < 24; i++) begin
      step();
      if (oBusy) busyCnt++;
    end
    check("busy_len", 32'(busyCnt), 32'(BUSY_LEN));

    // Loads during conversion are dropped; display keeps the first value.
    load(9999);
    run(LAT + 1);
    load(55);
    iData = DATA_W'(1234);
    iLoad = 1'b1;
    run(6);
    iLoad = 1'b0;
    run(3);
    iLoad = 1'b1;
    step();
    iLoad = 1'b0;
    run(20);
    capture("held_ignored", vecs[0].exp);
    load(1234);
    run(LAT + 1);
    capture("after_idle", 32'hF9A4B099);

    // Reset in the middle of a conversion discards it.
    load(4321);
    run(7);
    iRst = 1'b1;
    #1;
    check("async_busy", 32'(oBusy), 32'h0);
    check("async_com", 32'(oFndCom), 32'hF);
    check("async_font", 32'(oFndFont), 32'hFF);
    run(3);
    iRst = 1'b0;
    run(24);
    capture("post_rst", zeroFonts);

    // Random traffic, including strobes while busy and values around the overflow limit.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       iData = DATA_W'($urandom_range(9990, 10010));
        1:       iData = DATA_W'($urandom_range(0, 120));
        default: iData = DATA_W'($urandom_range(0, 16383));
      endcase
      iLoad = ($urandom_range(0, 5) == 0);
      step();
    end
    iLoad = 1'b0;
    run(LAT + 4 * DIV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
